// File: rtl/adder_ctrl_pkg.sv
// Shared types and helpers for controllers that time-share a datapath.
// Imported by the arbiter and by adder_share_ctrl.
package adder_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Index width for v entries, floored at 1 so single-bit fields stay legal.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr, wrapping.
// Zero latency; gnt is all-zero and any is low when nothing is requested.
module rr_arbiter
  import adder_ctrl_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr) + k) % N);
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// Shares one external W-bit adder among N requesters: round-robin grant, operand hold
// for SETTLE_CYCLES, result capture and a one-cycle ACK; REQ is ignored while busy.
module adder_share_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter  int W             = 64,
  parameter  int N             = 4,
  parameter  int SETTLE_CYCLES = 2,
  localparam int IW            = clog2(N)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [N-1:0]   REQ,
  input  logic [N-1:0]   REQ_SUB,
  input  logic [N*W-1:0] REQ_A,
  input  logic [N*W-1:0] REQ_B,
  output logic [N-1:0]   ACK,
  output logic [W-1:0]   RESULT,
  output logic           RESULT_COUT,
  output logic           RESULT_OVF,
  output logic [IW-1:0]  RESULT_ID,
  output logic           BUSY,
  output logic [W-1:0]   ADD_A,
  output logic [W-1:0]   ADD_B,
  output logic           ADD_CIN,
  input  logic [W-1:0]   ADD_SUM,
  input  logic           ADD_COUT
);

  localparam int CW = clog2(SETTLE_CYCLES + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] id_q, id_d;
  logic [N-1:0]  ack_d;
  logic [W-1:0]  res_d, a_d, b_d;
  logic          cout_d, ovf_d, cin_d;
  logic [IW-1:0] rid_d;

  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_idx;
  logic          gnt_any;

  rr_arbiter #(.N(N)) u_arb (
    .req (REQ),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    ack_d   = '0;
    res_d   = RESULT;
    cout_d  = RESULT_COUT;
    ovf_d   = RESULT_OVF;
    rid_d   = RESULT_ID;
    a_d     = ADD_A;
    b_d     = ADD_B;
    cin_d   = ADD_CIN;
    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          a_d     = REQ_A[gnt_idx*W +: W];
          b_d     = (REQ_SUB[gnt_idx] == OP_SUB) ? ~REQ_B[gnt_idx*W +: W] : REQ_B[gnt_idx*W +: W];
          cin_d   = REQ_SUB[gnt_idx];
          id_d    = gnt_idx;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          res_d   = ADD_SUM;
          cout_d  = ADD_COUT;
          // Same-sign operands giving a result of the other sign is signed overflow.
          ovf_d   = (ADD_A[W-1] == ADD_B[W-1]) && (ADD_SUM[W-1] != ADD_A[W-1]);
          rid_d   = id_q;
          ack_d   = N'(1) << id_q;
          ptr_d   = (id_q == IW'(N - 1)) ? '0 : id_q + 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      id_q        <= '0;
      ACK         <= '0;
      RESULT      <= '0;
      RESULT_COUT <= 1'b0;
      RESULT_OVF  <= 1'b0;
      RESULT_ID   <= '0;
      ADD_A       <= '0;
      ADD_B       <= '0;
      ADD_CIN     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      ACK         <= ack_d;
      RESULT      <= res_d;
      RESULT_COUT <= cout_d;
      RESULT_OVF  <= ovf_d;
      RESULT_ID   <= rid_d;
      ADD_A       <= a_d;
      ADD_B       <= b_d;
      ADD_CIN     <= cin_d;
    end
  end

  assign BUSY = (state_q == SETTLE) || (state_q == DONE);

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Bench for adder_share_ctrl with an ideal external adder; directed ops feed a
// scoreboard that a negedge monitor drains whenever ACK pulses.
module tb_adder_share_ctrl;

  localparam int W = 64;
  localparam int N = 4;

  logic           CLK, RST;
  logic [N-1:0]   REQ, REQ_SUB;
  logic [N*W-1:0] REQ_A, REQ_B;
  logic [N-1:0]   ACK;
  logic [W-1:0]   RESULT;
  logic           RESULT_COUT, RESULT_OVF;
  logic [1:0]     RESULT_ID;
  logic           BUSY;
  logic [W-1:0]   ADD_A, ADD_B, ADD_SUM;
  logic           ADD_CIN, ADD_COUT;

  adder_share_ctrl #(.W(W), .N(N), .SETTLE_CYCLES(2)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_SUB(REQ_SUB), .REQ_A(REQ_A), .REQ_B(REQ_B),
    .ACK(ACK), .RESULT(RESULT), .RESULT_COUT(RESULT_COUT), .RESULT_OVF(RESULT_OVF),
    .RESULT_ID(RESULT_ID), .BUSY(BUSY), .ADD_A(ADD_A), .ADD_B(ADD_B), .ADD_CIN(ADD_CIN),
    .ADD_SUM(ADD_SUM), .ADD_COUT(ADD_COUT)
  );

  // External ripple adder stand-in.
  assign {ADD_COUT, ADD_SUM} = {1'b0, ADD_A} + {1'b0, ADD_B} + {{W{1'b0}}, ADD_CIN};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int          id;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  logic [3:0] ack_prev = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push(input int id, input logic [63:0] s, input logic c, input logic o);
    exp_t e;
    e.id = id; e.sum = s; e.cout = c; e.ovf = o;
    sb.push_back(e);
  endtask

  always @(negedge CLK) begin
    if (!RST && ACK != '0) begin
      chk("ack_single_cycle", {60'd0, ack_prev}, 64'd0);
      if (sb.size() == 0) begin
        chk("unexpected_ack", {60'd0, ACK}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("ack_onehot", {60'd0, ACK}, 64'd1 << mon_e.id);
        chk("result", RESULT, mon_e.sum);
        chk("result_cout", {63'd0, RESULT_COUT}, {63'd0, mon_e.cout});
        chk("result_ovf", {63'd0, RESULT_OVF}, {63'd0, mon_e.ovf});
        chk("result_id", {62'd0, RESULT_ID}, 64'(mon_e.id));
        chk("busy_in_done", {63'd0, BUSY}, 64'd1);
      end
    end
    ack_prev = RST ? 4'b0 : ACK;
  end

  task automatic check_reset_outputs();
    chk("rst_ack", {60'd0, ACK}, 64'd0);
    chk("rst_result", RESULT, 64'd0);
    chk("rst_cout", {63'd0, RESULT_COUT}, 64'd0);
    chk("rst_ovf", {63'd0, RESULT_OVF}, 64'd0);
    chk("rst_id", {62'd0, RESULT_ID}, 64'd0);
    chk("rst_busy", {63'd0, BUSY}, 64'd0);
    chk("rst_add_a", ADD_A, 64'd0);
    chk("rst_add_b", ADD_B, 64'd0);
    chk("rst_add_cin", {63'd0, ADD_CIN}, 64'd0);
  endtask

  // Raise the requests in mask (all with the same op), wait for win's ACK, then drop them.
  task automatic do_op(input logic [3:0] mask, input int win, input logic sub,
                       input logic [63:0] a, input logic [63:0] b, input logic chg,
                       input logic [63:0] es, input logic ec, input logic eo);
    int n;
    @(negedge CLK);
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        REQ_A[i*W +: W] = a;
        REQ_B[i*W +: W] = b;
        REQ_SUB[i]      = sub;
      end
    end
    REQ = mask;
    push(win, es, ec, eo);
    n = 0;
    while (n < 20) begin
      @(negedge CLK);
      n++;
      if (chg && n == 1) REQ_A[win*W +: W] = 64'd99;
      if (ACK[win]) break;
    end
    chk("ack_latency", 64'(n), 64'd3);
    REQ = '0;
  endtask

  initial begin
    int n_ack, prev, t;
    RST = 1'b1; REQ = '0; REQ_SUB = '0; REQ_A = '0; REQ_B = '0;
    repeat (3) @(negedge CLK);
    check_reset_outputs();
    RST = 1'b0;

    do_op(4'b0010, 1, 1'b0, 64'd5, 64'd7, 1'b0, 64'd12, 1'b0, 1'b0);
    do_op(4'b0001, 0, 1'b1, 64'd3, 64'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    do_op(4'b0001, 0, 1'b1, 64'd5, 64'd3, 1'b0, 64'd2, 1'b1, 1'b0);
    do_op(4'b0100, 2, 1'b0, 64'd10, 64'd1, 1'b1, 64'd11, 1'b0, 1'b0);
    do_op(4'b1000, 3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0);
    do_op(4'b1000, 3, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);

    // Round-robin with all four requesting; pointer is back at 0 here.
    @(negedge CLK);
    for (int i = 0; i < N; i++) begin
      REQ_A[i*W +: W] = 64'(100 + i);
      REQ_B[i*W +: W] = 64'(i);
      REQ_SUB[i]      = 1'b0;
    end
    push(0, 64'd100, 1'b0, 1'b0);
    push(1, 64'd102, 1'b0, 1'b0);
    push(2, 64'd104, 1'b0, 1'b0);
    push(3, 64'd106, 1'b0, 1'b0);
    push(0, 64'd100, 1'b0, 1'b0);
    REQ = 4'b1111;
    n_ack = 0; prev = -1;
    for (t = 1; t <= 60 && n_ack < 5; t++) begin
      @(negedge CLK);
      if (ACK != '0) begin
        if (prev >= 0) chk("grant_spacing", 64'(t - prev), 64'd4);
        prev = t;
        n_ack++;
        REQ = (n_ack == 5) ? 4'b0000 : (4'b1111 & ~ACK);
      end else begin
        REQ = 4'b1111;
      end
    end
    chk("fair_ack_count", 64'(n_ack), 64'd5);
    REQ = '0;

    // Reset during SETTLE: pointer is 1 at this point, so the 0011 request below exposes it.
    @(negedge CLK);
    @(negedge CLK);
    REQ_A[2*W +: W] = 64'd40; REQ_B[2*W +: W] = 64'd2; REQ_SUB[2] = 1'b0;
    REQ = 4'b0100;
    @(negedge CLK);
    chk("busy_after_grant", {63'd0, BUSY}, 64'd1);
    RST = 1'b1; REQ = '0;
    @(negedge CLK);
    check_reset_outputs();
    RST = 1'b0;
    repeat (6) @(negedge CLK);
    do_op(4'b0011, 0, 1'b0, 64'd20, 64'd22, 1'b0, 64'd42, 1'b0, 1'b0);
    do_op(4'b1000, 3, 1'b0, 64'd1, 64'd2, 1'b0, 64'd3, 1'b0, 1'b0);

    repeat (5) @(negedge CLK);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
